// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   ALU_W        default datapath width
//   alu_op_e     dense 4-bit operation code (every encoding is legal)
//   alu_state_e  control FSM states
//   helpers classifying ops into iterative / divide / signed
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLT   = 4'd2,
        OP_SLTU  = 4'd3,
        OP_AND   = 4'd4,
        OP_NOR   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_LUI   = 4'd11,
        OP_MULT  = 4'd12,
        OP_MULTU = 4'd13,
        OP_DIV   = 4'd14,
        OP_DIVU  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    function automatic logic is_iter_op(input alu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input alu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input alu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/pipe_alu_if.sv
// pipe_alu_if: request/response bundle of the pipelined ALU.
//   request : in_valid/in_ready handshake, op, src1, src2, flush
//   response: out_valid/out_ready handshake, result, result_hi, adder_cout,
//             busy, and overflow when PIPE_ALU_OVERFLOW_EN is defined
//   master = requester/consumer side, slave = the ALU.
interface pipe_alu_if
    import alu_pkg::*;
#(
    parameter int W = ALU_W
);
    logic          in_valid;
    logic          in_ready;
    alu_op_e       op;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          adder_cout;
    logic          busy;
`ifdef PIPE_ALU_OVERFLOW_EN
    logic          overflow;
`endif

    modport master (
        output in_valid, op, src1, src2, flush, out_ready,
`ifdef PIPE_ALU_OVERFLOW_EN
        input  overflow,
`endif
        input  in_ready, out_valid, result, result_hi, adder_cout, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, flush, out_ready,
`ifdef PIPE_ALU_OVERFLOW_EN
        output overflow,
`endif
        output in_ready, out_valid, result, result_hi, adder_cout, busy
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: bit-serial multiply / restoring divide, one bit per cycle.
//   i_start   load operands (magnitudes + sign info) on this edge
//   i_kill    abandon any running operation
//   i_div     1 = divide, 0 = multiply;  i_signed 1 = two's complement operands
//   o_done    high during the last of the W step cycles; o_lo/o_hi then carry
//             the final, sign-corrected result (combinational from that step)
//   o_lo/o_hi product low/high half, or quotient/remainder
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = ALU_W
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_kill,
    input  logic         i_start,
    input  logic         i_div,
    input  logic         i_signed,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi
);
    localparam int CW = $clog2(W);

    logic          r_run;
    logic [CW-1:0] r_cnt;
    logic          r_div;
    logic          r_neg_lo;   // product / quotient negative
    logic          r_neg_hi;   // remainder negative (follows dividend)
    logic          r_dz;       // divide by zero
    logic [W-1:0]  r_hi;       // partial product high / partial remainder
    logic [W-1:0]  r_lo;       // multiplier / dividend, shifting into result
    logic [W-1:0]  r_b;        // |multiplicand| or |divisor|

    logic          w_sa, w_sb;
    logic [W:0]    w_madd;
    logic [W:0]    w_t;
    logic          w_ge;
    logic [W-1:0]  w_tsub;
    logic [W-1:0]  w_nhi, w_nlo;
    logic [2*W-1:0] w_prod, w_prod_s;
    logic [W-1:0]  w_q, w_r;

    assign w_sa = i_signed & i_a[W-1];
    assign w_sb = i_signed & i_b[W-1];

    // One step of each algorithm from the current registers.
    assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    assign w_t    = {r_hi, r_lo[W-1]};
    assign w_ge   = (w_t >= {1'b0, r_b});
    // Taken only when w_t < 2*r_b, so the difference always fits W bits.
    assign w_tsub = w_t[W-1:0] - r_b;

    always_comb begin
        w_nhi = r_hi;
        w_nlo = r_lo;
        if (r_div) begin
            w_nhi = w_ge ? w_tsub : w_t[W-1:0];
            w_nlo = {r_lo[W-2:0], w_ge};
        end else begin
            w_nhi = w_madd[W:1];
            w_nlo = {w_madd[0], r_lo[W-1:1]};
        end
    end

    // Sign correction applied to the outcome of the final step.
    // MIN/-1 needs no special case: |MIN| negated wraps back to MIN.
    assign w_prod   = {w_nhi, w_nlo};
    assign w_prod_s = r_neg_lo ? -w_prod : w_prod;
    assign w_q      = r_dz ? {W{1'b1}} : (r_neg_lo ? -w_nlo : w_nlo);
    assign w_r      = r_neg_hi ? -w_nhi : w_nhi;

    assign o_done = r_run && (r_cnt == CW'(W-1));
    assign o_lo   = r_div ? w_q : w_prod_s[W-1:0];
    assign o_hi   = r_div ? w_r : w_prod_s[2*W-1:W];

    always_ff @(posedge clk) begin
        if (reset || i_kill) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_div    <= i_div;
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= w_sa;
            r_dz     <= (i_b == '0);
            r_hi     <= '0;
            r_lo     <= w_sa ? -i_a : i_a;
            r_b      <= w_sb ? -i_b : i_b;
        end else if (r_run) begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(W-1))
                r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_alu.sv
// pipe_alu: valid/ready ALU. Single-cycle ops answer one cycle after accept;
// MULT/MULTU/DIV/DIVU spend W cycles in ITER and answer W+1 cycles after accept.
// Results are held in HOLD until out_ready; a new request can be taken in the
// same cycle the held result is consumed.
//   clk, reset  clock and synchronous active-high reset
//   bus         pipe_alu_if.slave (request, response, flush, busy)
// Optional macro PIPE_ALU_OVERFLOW_EN adds bus.overflow (signed overflow of
// ADD/SUB, 0 otherwise).
module pipe_alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W
)
(
    input  logic      clk,
    input  logic      reset,
    pipe_alu_if.slave bus
);
    localparam int SHW = $clog2(W);

    alu_state_e    r_state;
    logic          r_out_valid;
    logic          r_busy;
    logic [W-1:0]  r_result;
    logic [W-1:0]  r_result_hi;
    logic          r_cout;
`ifdef PIPE_ALU_OVERFLOW_EN
    logic          r_ovf;
`endif

    logic          w_in_ready, w_accept, w_start, w_is_sub, w_is_addsub;
    logic [W-1:0]  w_b_op, w_lo;
    logic [W:0]    w_sum;
    logic          w_ovf;
    logic [SHW-1:0] w_shamt;
    logic          w_md_done;
    logic [W-1:0]  w_md_lo, w_md_hi;

    assign w_in_ready = !reset && !bus.flush &&
                        ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_start    = w_accept && is_iter_op(bus.op);

    // Shared adder: SUB is src1 + ~src2 + 1.
    assign w_is_sub    = (bus.op == OP_SUB);
    assign w_is_addsub = (bus.op == OP_ADD) || w_is_sub;
    assign w_b_op      = w_is_sub ? ~bus.src2 : bus.src2;
    assign w_sum       = {1'b0, bus.src1} + {1'b0, w_b_op} + {{W{1'b0}}, w_is_sub};
    assign w_ovf       = (bus.src1[W-1] == w_b_op[W-1]) && (w_sum[W-1] != bus.src1[W-1]);
    assign w_shamt     = bus.src1[SHW-1:0];

    always_comb begin
        w_lo = '0;
        case (bus.op)
            OP_ADD, OP_SUB: w_lo = w_sum[W-1:0];
            OP_SLT:  w_lo = {{(W-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
            OP_SLTU: w_lo = {{(W-1){1'b0}}, (bus.src1 < bus.src2)};
            OP_AND:  w_lo = bus.src1 & bus.src2;
            OP_NOR:  w_lo = ~(bus.src1 | bus.src2);
            OP_OR:   w_lo = bus.src1 | bus.src2;
            OP_XOR:  w_lo = bus.src1 ^ bus.src2;
            OP_SLL:  w_lo = bus.src2 << w_shamt;
            OP_SRL:  w_lo = bus.src2 >> w_shamt;
            OP_SRA:  w_lo = $signed(bus.src2) >>> w_shamt;
            OP_LUI:  w_lo = {bus.src2[W/2-1:0], {(W/2){1'b0}}};
            default: w_lo = '0;
        endcase
    end

    alu_muldiv_iter #(.W(W)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_kill   (bus.flush),
        .i_start  (w_start),
        .i_div    (is_div_op(bus.op)),
        .i_signed (is_signed_op(bus.op)),
        .i_a      (bus.src1),
        .i_b      (bus.src2),
        .o_done   (w_md_done),
        .o_lo     (w_md_lo),
        .o_hi     (w_md_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_cout      <= 1'b0;
`ifdef PIPE_ALU_OVERFLOW_EN
            r_ovf       <= 1'b0;
`endif
        end else if (bus.flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_ITER: begin
                    if (w_md_done) begin
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_result    <= w_md_lo;
                        r_result_hi <= w_md_hi;
                        r_cout      <= 1'b0;
`ifdef PIPE_ALU_OVERFLOW_EN
                        r_ovf       <= 1'b0;
`endif
                    end
                end
                default: begin  // IDLE or HOLD
                    if (w_accept) begin
                        if (is_iter_op(bus.op)) begin
                            r_state     <= ST_ITER;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state     <= ST_HOLD;
                            r_out_valid <= 1'b1;
                            r_result    <= w_lo;
                            r_result_hi <= '0;
                            r_cout      <= w_is_addsub ? w_sum[W] : 1'b0;
`ifdef PIPE_ALU_OVERFLOW_EN
                            r_ovf       <= w_is_addsub ? w_ovf : 1'b0;
`endif
                        end
                    end else if ((r_state != ST_HOLD) || bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = r_busy;
    assign bus.result     = r_result;
    assign bus.result_hi  = r_result_hi;
    assign bus.adder_cout = r_cout;
`ifdef PIPE_ALU_OVERFLOW_EN
    assign bus.overflow   = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = w_ovf;
`endif

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter: W, default 32, datapath width; legal values are powers of two, 8..64.
REQ-002 Parameter: SHW, default $clog2(W), shift-amount width (derived, not overridable).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted when in_valid & in_ready.
REQ-007 op  input  4  operation code: ADD, SUB, SLT, SLTU, AND, NOR, OR, XOR, SLL, SRL, SRA, LUI, MULT, MULTU, DIV, DIVU.
REQ-008 src1  input  W  operand 1 (two's complement); src1[SHW-1:0] is the shift amount.
REQ-009 src2  input  W  operand 2 (two's complement); also the shifted/LUI operand.
REQ-010 flush  input  1  abort any in-flight operation.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  result consumed when out_valid & out_ready.
REQ-013 result  output  W  low result (quotient for DIV*).
REQ-014 result_hi  output  W  MULT*: product high half; DIV*: remainder; otherwise 0.
REQ-015 adder_cout  output  1  carry out of the W-bit add/sub, as for the existing ALU.
REQ-016 busy  output  1  iterative operation in progress.

Function
REQ-017 The FSM has the states IDLE, ITER and HOLD.
REQ-018 in_ready is 1 only in IDLE, or in HOLD with out_ready=1.
REQ-019 Single-cycle ops go from accept to HOLD with out_valid=1 on the next cycle (latency 1).
REQ-020 MULT/MULTU/DIV/DIVU go from accept to ITER for exactly W cycles (one bit per cycle), then to HOLD (latency W+1).
REQ-021 In HOLD, outputs are held stable until out_ready=1.
REQ-022 On HOLD & out_ready with a new accept, the new request is taken the same cycle (back-to-back, no bubble); otherwise the FSM returns to IDLE.
REQ-023 ADD/SUB: W-bit wraparound; SUB computes src1 + ~src2 + 1; adder_cout is valid with the result.
REQ-024 SLT is a signed compare and SLTU an unsigned compare; each gives result {W-1 zeros, lt}.
REQ-025 SLL/SRL/SRA shift src2 by src1[SHW-1:0]; SRA fills with src2[W-1].
REQ-026 LUI gives {src2[W/2-1:0], W/2 zeros}.
REQ-027 MULT/MULTU give the full 2W-bit product split as {result_hi, result}; MULT is signed.
REQ-028 Signed mul/div operate on magnitudes; signs are corrected in the final ITER cycle.
REQ-029 DIV: the quotient truncates toward zero, and the remainder takes the sign of src1.
REQ-030 Divide by zero gives result = all ones and result_hi = src1, with normal latency.
REQ-031 DIV of MIN / -1 gives result = MIN and result_hi = 0.
REQ-032 flush=1 has the following effects in any state:
  - the next state is IDLE;
  - out_valid and busy go to 0;
  - no request is accepted that cycle (in_ready=0).
REQ-033 An undefined op code is impossible (the encoding is dense).

Reset
REQ-034 reset takes priority over flush and the handshakes.
REQ-035 After reset, the block is in IDLE with out_valid=0, busy=0, result=0, result_hi=0 and adder_cout=0.
REQ-036 reset asserted mid-ITER discards the operation; no out_valid follows.

Configuration
REQ-037 Macro PIPE_ALU_OVERFLOW_EN:
  - Defined: adds output overflow (1 bit), set on signed overflow of ADD/SUB, registered with result and 0 for all other ops.
  - Undefined: the port and its logic are absent.

Structure
REQ-038 Package alu_pkg holds the op enum typedef, the FSM state typedef and the default W.
REQ-039 The iterative multiply/divide lives in sub-module alu_muldiv_iter (start, done, signed flag, W-cycle counter); the single-cycle ops stay in pipe_alu.

Verification (W=32)
REQ-040 ADD 0x7FFFFFFF+1, out_ready=1 → out_valid next cycle; result=0x80000000, adder_cout=0, overflow=1 (macro on).
REQ-041 MULT 0xFFFFFFFE*3 → out_valid 33 cycles after accept; {result_hi,result}=0xFFFFFFFF_FFFFFFFA; busy=1 during ITER.
REQ-042 Both division cases:
  - DIV -7/2 → result=0xFFFFFFFD, result_hi=0xFFFFFFFF.
  - DIVU 5/0 → result=0xFFFFFFFF, result_hi=5.
REQ-043 SRA 0x80000000 by 4 → 0xF8000000, with out_ready=0 for 3 cycles; outputs stay stable and in_ready=0 until release.
REQ-044 Back-to-back SLTU(1,2) then SLT(-1,1), out_ready=1 → results 1,1 on consecutive cycles with no bubble.
REQ-045 DIVU, flush on ITER cycle 10, then ADD 2+3 → no stale out_valid; ADD result 5 one cycle after its accept.
